// File: rtl/sdram_arb2_if.sv
// Bus bundle between two requesters, the arbiter and the SDRAM controller slave.
// The slave modport is the arbiter's view; the master modport is the surrounding system.
// Requester ports use Avalon-MM naming: waitrequest stalls the command, readdatavalid marks data.
interface sdram_arb2_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0]   s0_address,   s1_address;
  logic                s0_read,      s1_read;
  logic                s0_write,     s1_write;
  logic [DATA_W-1:0]   s0_writedata, s1_writedata;
  logic [DATA_W/8-1:0] s0_byteenable, s1_byteenable;
  logic                s0_waitrequest, s1_waitrequest;
  logic [DATA_W-1:0]   s0_readdata,  s1_readdata;
  logic                s0_readdatavalid, s1_readdatavalid;

  logic [ADDR_W-1:0]   m_address;
  logic                m_read, m_write;
  logic [DATA_W-1:0]   m_writedata;
  logic [DATA_W/8-1:0] m_byteenable;
  logic                m_waitrequest;
  logic [DATA_W-1:0]   m_readdata;
  logic                m_readdatavalid;

  modport slave (
    input  s0_address, s0_read, s0_write, s0_writedata, s0_byteenable,
    input  s1_address, s1_read, s1_write, s1_writedata, s1_byteenable,
    output s0_waitrequest, s0_readdata, s0_readdatavalid,
    output s1_waitrequest, s1_readdata, s1_readdatavalid,
    output m_address, m_read, m_write, m_writedata, m_byteenable,
    input  m_waitrequest, m_readdata, m_readdatavalid
  );

  modport master (
    output s0_address, s0_read, s0_write, s0_writedata, s0_byteenable,
    output s1_address, s1_read, s1_write, s1_writedata, s1_byteenable,
    input  s0_waitrequest, s0_readdata, s0_readdatavalid,
    input  s1_waitrequest, s1_readdata, s1_readdatavalid,
    input  m_address, m_read, m_write, m_writedata, m_byteenable,
    output m_waitrequest, m_readdata, m_readdatavalid
  );
endinterface

// File: rtl/sdram_arb2.sv
// Two-requester round-robin arbiter in front of a pipelined SDRAM controller slave.
// Latency: command passes combinationally once granted (grant takes one cycle from IDLE); read data zero added latency.
// Backpressure: m_waitrequest and a full read-tag FIFO both hold the owner via its waitrequest.
module sdram_arb2 #(
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 16,
  parameter int MAX_PEND = 8
) (
  input  logic                       clk_clk,
  input  logic                       reset_reset,
  sdram_arb2_if.slave                bus,
  output logic [$clog2(MAX_PEND):0]  pend_count,
  output logic                       err_underflow
);
  localparam int PW = $clog2(MAX_PEND);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t          state;
  logic            last_served;
  logic [MAX_PEND-1:0] tag_mem;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;

  logic req0, req1, own_sel, own_active;
  logic sel_read, sel_write;
  logic fifo_full, fifo_empty, pop, push, accept, head;

  assign req0       = bus.s0_read | bus.s0_write;
  assign req1       = bus.s1_read | bus.s1_write;
  assign own_active = (state != IDLE);
  assign own_sel    = (state == OWN1);

  assign sel_read   = own_sel ? bus.s1_read  : bus.s0_read;
  assign sel_write  = own_sel ? bus.s1_write : bus.s0_write;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(MAX_PEND));
  assign pop        = bus.m_readdatavalid & ~fifo_empty;
  assign head       = tag_mem[rd_ptr];

  // Command mux: the owner's bus goes straight through; strobes are gated
  // so nothing reaches the controller while idle. A pop in the same cycle
  // frees a slot, so a full FIFO only stalls reads when nothing is returning.
  always_comb begin
    bus.m_address    = own_sel ? bus.s1_address    : bus.s0_address;
    bus.m_writedata  = own_sel ? bus.s1_writedata  : bus.s0_writedata;
    bus.m_byteenable = own_sel ? bus.s1_byteenable : bus.s0_byteenable;
    bus.m_write      = own_active & sel_write;
    bus.m_read       = own_active & sel_read & ~sel_write & ~(fifo_full & ~pop);
  end

  assign accept = (bus.m_read | bus.m_write) & ~bus.m_waitrequest;
  assign push   = accept & bus.m_read;

  assign bus.s0_waitrequest = ~(accept & (state == OWN0));
  assign bus.s1_waitrequest = ~(accept & (state == OWN1));

  // Read data is broadcast; only the valid strobe follows the head tag.
  assign bus.s0_readdata      = bus.m_readdata;
  assign bus.s1_readdata      = bus.m_readdata;
  assign bus.s0_readdatavalid = pop & ~head;
  assign bus.s1_readdatavalid = pop &  head;

  assign pend_count = count;

  // Grant FSM: round-robin on ties, hand over directly on acceptance,
  // drop back to IDLE if the owner withdraws its strobe.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state       <= IDLE;
      last_served <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req0 && req1) state <= last_served ? OWN0 : OWN1;
          else if (req0)    state <= OWN0;
          else if (req1)    state <= OWN1;
        end
        OWN0: begin
          if (accept) begin
            last_served <= 1'b0;
            state       <= req1 ? OWN1 : IDLE;
          end else if (!req0) begin
            state <= IDLE;
          end
        end
        OWN1: begin
          if (accept) begin
            last_served <= 1'b1;
            state       <= req0 ? OWN0 : IDLE;
          end else if (!req1) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag FIFO of owner ids for outstanding reads, plus the sticky underflow flag.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      err_underflow <= 1'b0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= own_sel;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (bus.m_readdatavalid && fifo_empty) err_underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sdram_arb2.sv
// Self-checking bench for sdram_arb2: grant order, write pass-through, read routing,
// full tag FIFO, underflow and reset behaviour. Read responses are checked by a
// scoreboard of (requester, data) entries popped whenever a requester sees valid data.
module tb_sdram_arb2;
  logic       clk_clk = 1'b0;
  logic       reset_reset;
  logic [3:0] pend_count;
  logic       err_underflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic [15:0] data;
  } exp_t;
  exp_t exp_q[$];

  sdram_arb2_if #(.ADDR_W(24), .DATA_W(16)) bus ();

  sdram_arb2 #(.ADDR_W(24), .DATA_W(16), .MAX_PEND(8)) dut (
    .clk_clk       (clk_clk),
    .reset_reset   (reset_reset),
    .bus           (bus),
    .pend_count    (pend_count),
    .err_underflow (err_underflow)
  );

  always #5 clk_clk = ~clk_clk;

  // Response monitor: every routed valid must match the scoreboard head.
  always @(negedge clk_clk) begin
    if (bus.s0_readdatavalid || bus.s1_readdatavalid) begin
      checks++;
      if (bus.s0_readdatavalid && bus.s1_readdatavalid) begin
        errors++;
        $display("FAIL rdv_both: s0 and s1 valid together");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rdv_unexpected: s0v=%0b s1v=%0b with empty scoreboard",
                 bus.s0_readdatavalid, bus.s1_readdatavalid);
      end else begin
        exp_t e;
        int   got_id;
        logic [15:0] got_data;
        e        = exp_q.pop_front();
        got_id   = bus.s1_readdatavalid ? 1 : 0;
        got_data = bus.s1_readdatavalid ? bus.s1_readdata : bus.s0_readdata;
        if (got_id !== e.id || got_data !== e.data) begin
          errors++;
          $display("FAIL rdv_route: got id=%0d data=%h, expected id=%0d data=%h",
                   got_id, got_data, e.id, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic init_inputs();
    reset_reset           = 1'b0;
    bus.s0_address        = '0; bus.s1_address    = '0;
    bus.s0_read           = 0;  bus.s1_read       = 0;
    bus.s0_write          = 0;  bus.s1_write      = 0;
    bus.s0_writedata      = '0; bus.s1_writedata  = '0;
    bus.s0_byteenable     = '0; bus.s1_byteenable = '0;
    bus.m_waitrequest     = 1'b0;
    bus.m_readdata        = '0;
    bus.m_readdatavalid   = 1'b0;
  endtask

  task automatic do_reset();
    reset_reset = 1'b1;
    tick();
    tick();
    reset_reset = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (bus.m_read !== 1'b0 || bus.m_write !== 1'b0 ||
        bus.s0_waitrequest !== 1'b1 || bus.s1_waitrequest !== 1'b1 ||
        bus.s0_readdatavalid !== 1'b0 || bus.s1_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL %s: m_read=%b m_write=%b w0=%b w1=%b v0=%b v1=%b, expected 0 0 1 1 0 0",
               name, bus.m_read, bus.m_write, bus.s0_waitrequest, bus.s1_waitrequest,
               bus.s0_readdatavalid, bus.s1_readdatavalid);
    end
  endtask

  task automatic check_pend(input string name, input logic [3:0] exp_cnt);
    checks++;
    if (pend_count !== exp_cnt) begin
      errors++;
      $display("FAIL %s: pend_count=%0d expected %0d", name, pend_count, exp_cnt);
    end
  endtask

  // Hold a read strobe until accepted (bounded), then release it.
  task automatic issue_read(input int id, input logic [23:0] addr);
    bit ok = 0;
    if (id == 0) begin bus.s0_address = addr; bus.s0_read = 1'b1; end
    else         begin bus.s1_address = addr; bus.s1_read = 1'b1; end
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk_clk);
      if ((id == 0 && !bus.s0_waitrequest) || (id == 1 && !bus.s1_waitrequest)) ok = 1;
      tick();
    end
    bus.s0_read = 1'b0;
    bus.s1_read = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL issue_read: requester %0d read not accepted within 20 cycles", id);
    end
  endtask

  task automatic send_resp(input int id, input logic [15:0] data);
    exp_t e;
    e.id = id;
    e.data = data;
    exp_q.push_back(e);
    bus.m_readdata      = data;
    bus.m_readdatavalid = 1'b1;
    tick();
    bus.m_readdatavalid = 1'b0;
  endtask

  task automatic test_reset();
    reset_reset  = 1'b1;
    bus.s0_read  = 1'b1;
    bus.s1_write = 1'b1;
    tick();
    @(negedge clk_clk);
    check_idle_outputs("reset_outputs");
    check_pend("reset_pend", 4'd0);
    checks++;
    if (err_underflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: err_underflow=%b expected 0", err_underflow);
    end
    tick();
    bus.s0_read  = 1'b0;
    bus.s1_write = 1'b0;
    reset_reset  = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    bus.s0_address    = 24'h000123;
    bus.s0_writedata  = 16'hBEEF;
    bus.s0_byteenable = 2'b11;
    bus.s0_write      = 1'b1;
    bus.m_waitrequest = 1'b0;
    @(negedge clk_clk);
    check_idle_outputs("write_grant_cycle");
    tick();
    @(negedge clk_clk);
    checks++;
    if (bus.m_write !== 1'b1 || bus.m_address !== 24'h000123 ||
        bus.m_writedata !== 16'hBEEF || bus.m_byteenable !== 2'b11 ||
        bus.s0_waitrequest !== 1'b0 || bus.m_read !== 1'b0) begin
      errors++;
      $display("FAIL write_accept: m_write=%b addr=%h data=%h be=%b w0=%b m_read=%b, expected 1 000123 beef 11 0 0",
               bus.m_write, bus.m_address, bus.m_writedata, bus.m_byteenable,
               bus.s0_waitrequest, bus.m_read);
    end
    tick();
    bus.s0_write = 1'b0;
    @(negedge clk_clk);
    check_idle_outputs("write_after");
    check_pend("write_pend", 4'd0);
  endtask

  task automatic test_round_robin();
    int exp_g[5] = '{2, 0, 1, 0, 1};
    do_reset();
    bus.s0_address = 24'h000010;
    bus.s1_address = 24'h000020;
    bus.s0_read = 1'b1;
    bus.s1_read = 1'b1;
    for (int c = 0; c < 5; c++) begin
      int g;
      logic [23:0] exp_addr;
      @(negedge clk_clk);
      g = !bus.s0_waitrequest ? 0 : (!bus.s1_waitrequest ? 1 : 2);
      exp_addr = (exp_g[c] == 1) ? 24'h000020 : 24'h000010;
      checks++;
      if (g !== exp_g[c] || (g != 2 && bus.m_address !== exp_addr)) begin
        errors++;
        $display("FAIL rr_grant[%0d]: grant=%0d addr=%h, expected grant=%0d addr=%h",
                 c, g, bus.m_address, exp_g[c], exp_addr);
      end
      tick();
    end
    bus.s0_read = 1'b0;
    bus.s1_read = 1'b0;
    tick();
    @(negedge clk_clk);
    check_pend("rr_pend", 4'd4);
    tick();
    send_resp(0, 16'hA000);
    send_resp(1, 16'hA001);
    send_resp(0, 16'hA002);
    send_resp(1, 16'hA003);
    @(negedge clk_clk);
    check_pend("rr_drain", 4'd0);
  endtask

  task automatic test_routing();
    issue_read(0, 24'h0000A0);
    issue_read(1, 24'h0000B0);
    issue_read(0, 24'h0000C0);
    @(negedge clk_clk);
    check_pend("route_peak", 4'd3);
    tick();
    send_resp(0, 16'h1111);
    send_resp(1, 16'h2222);
    send_resp(0, 16'h3333);
    @(negedge clk_clk);
    check_pend("route_drain", 4'd0);
  endtask

  task automatic test_full_fifo();
    int ids[9];
    for (int i = 0; i < 8; i++) begin
      ids[i] = i % 2;
      issue_read(ids[i], 24'(i));
    end
    ids[8] = 0;
    @(negedge clk_clk);
    check_pend("full_pend", 4'd8);
    tick();
    bus.s0_address = 24'h000099;
    bus.s0_read    = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_clk);
      checks++;
      if (bus.m_read !== 1'b0 || bus.s0_waitrequest !== 1'b1) begin
        errors++;
        $display("FAIL full_stall[%0d]: m_read=%b w0=%b, expected 0 1",
                 c, bus.m_read, bus.s0_waitrequest);
      end
      tick();
    end
    begin
      exp_t e;
      e.id = ids[0];
      e.data = 16'hF000;
      exp_q.push_back(e);
    end
    bus.m_readdata      = 16'hF000;
    bus.m_readdatavalid = 1'b1;
    @(negedge clk_clk);
    checks++;
    if (bus.m_read !== 1'b1 || bus.s0_waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL full_pop_accept: m_read=%b w0=%b, expected 1 0",
               bus.m_read, bus.s0_waitrequest);
    end
    tick();
    bus.m_readdatavalid = 1'b0;
    bus.s0_read = 1'b0;
    @(negedge clk_clk);
    check_pend("full_pend_after", 4'd8);
    tick();
    for (int k = 1; k < 9; k++) send_resp(ids[k], 16'hF000 + 16'(k));
    @(negedge clk_clk);
    check_pend("full_drain", 4'd0);
  endtask

  task automatic test_underflow_reset();
    bus.m_readdata      = 16'hDEAD;
    bus.m_readdatavalid = 1'b1;
    @(negedge clk_clk);
    checks++;
    if (bus.s0_readdatavalid !== 1'b0 || bus.s1_readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL uf_no_valid: v0=%b v1=%b expected 0 0",
               bus.s0_readdatavalid, bus.s1_readdatavalid);
    end
    tick();
    bus.m_readdatavalid = 1'b0;
    @(negedge clk_clk);
    checks++;
    if (err_underflow !== 1'b1) begin
      errors++;
      $display("FAIL uf_set: err_underflow=%b expected 1", err_underflow);
    end
    tick();
    reset_reset = 1'b1;
    tick();
    reset_reset = 1'b0;
    @(negedge clk_clk);
    checks++;
    if (err_underflow !== 1'b0) begin
      errors++;
      $display("FAIL uf_clear: err_underflow=%b expected 0", err_underflow);
    end
    tick();
    bus.m_waitrequest = 1'b1;
    bus.s1_address    = 24'h000555;
    bus.s1_write      = 1'b1;
    tick();
    @(negedge clk_clk);
    checks++;
    if (bus.m_write !== 1'b1 || bus.s1_waitrequest !== 1'b1 || bus.m_address !== 24'h000555) begin
      errors++;
      $display("FAIL own1_wait: m_write=%b w1=%b addr=%h, expected 1 1 000555",
               bus.m_write, bus.s1_waitrequest, bus.m_address);
    end
    tick();
    reset_reset = 1'b1;
    tick();
    @(negedge clk_clk);
    check_idle_outputs("reset_mid_own1");
    tick();
    reset_reset       = 1'b0;
    bus.s1_write      = 1'b0;
    bus.m_waitrequest = 1'b0;
    tick();
    bus.m_readdata      = 16'hBAD0;
    bus.m_readdatavalid = 1'b1;
    tick();
    bus.m_readdatavalid = 1'b0;
    @(negedge clk_clk);
    checks++;
    if (err_underflow !== 1'b1) begin
      errors++;
      $display("FAIL stale_resp: err_underflow=%b expected 1", err_underflow);
    end
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_single_write();
    test_round_robin();
    test_routing();
    test_full_fifo();
    test_underflow_reset();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d responses never delivered, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
